parking_gate_ctrl: RTL and testbench

Downstream stage of the parking password FSM: consumes its `out` grant level and drives the entry barrier motor through an open/hold/close cycle. Counts cars parked against a fixed capacity and refuses to open when full. Includes a safety reversal if a car enters the beam while the barrier is closing.

---
 rtl/parking_gate_ctrl.sv | 98 +++++++++
 tb/tb_parking_gate_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry barrier sequencer with occupancy count and safety reversal.
// Define GATE_ALARM_EN to build the sticky forced-entry alarm; otherwise alarm is tied low.
module parking_gate_ctrl #(
  parameter int CAPACITY      = 8,
  parameter int CNT_W         = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int HOLD_MAX      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grant,
  input  logic             beam,
  input  logic             exit_car,
  output logic             motor_up,
  output logic             motor_down,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             alarm
);
  localparam int TMAX = (TRAVEL_CYCLES > HOLD_MAX) ? TRAVEL_CYCLES : HOLD_MAX;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] H_LAST = TW'(HOLD_MAX - 1);
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic seen, seen_nx, grant_q, grant_rise, accept, entry;
  assign grant_rise = grant & ~grant_q;
  assign full       = occupancy == CNT_W'(CAPACITY);
  assign accept     = (state == CLOSED) & grant_rise & ~full;
  assign motor_up   = state == OPENING;
  assign motor_down = state == CLOSING;
  assign gate_open  = state == OPEN;
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    seen_nx  = seen;
    entry    = 1'b0;
    case (state)
      CLOSED: if (accept) begin
        state_nx = OPENING;
        tmr_nx   = '0;
        seen_nx  = 1'b0;
      end
      OPENING: if (tmr == T_LAST) begin
        state_nx = OPEN;
        tmr_nx   = '0;
      end else tmr_nx = tmr + TW'(1);
      OPEN: if (beam) seen_nx = 1'b1;
      else if (seen) begin
        state_nx = CLOSING;
        entry    = 1'b1;
        tmr_nx   = '0;
      end else if (tmr == H_LAST) begin
        state_nx = CLOSING;
        tmr_nx   = '0;
      end else tmr_nx = tmr + TW'(1);
      CLOSING: if (beam) begin
        state_nx = OPENING;
        tmr_nx   = '0;
        seen_nx  = 1'b0;
      end else if (tmr == T_LAST) begin
        state_nx = CLOSED;
        tmr_nx   = '0;
      end else tmr_nx = tmr + TW'(1);
      default: state_nx = CLOSED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CLOSED;
      tmr       <= '0;
      seen      <= 1'b0;
      grant_q   <= 1'b0;
      occupancy <= '0;
    end else begin
      state   <= state_nx;
      tmr     <= tmr_nx;
      seen    <= seen_nx;
      grant_q <= grant;
      // simultaneous entry and exit cancel; saturate at both ends
      if (entry && !exit_car && !full) occupancy <= occupancy + CNT_W'(1);
      else if (exit_car && !entry && occupancy != '0) occupancy <= occupancy - CNT_W'(1);
    end
  end
`ifdef GATE_ALARM_EN
  logic alarm_q;
  always_ff @(posedge clk) begin
    if (!reset) alarm_q <= 1'b0;
    else if (beam && state == CLOSED) alarm_q <= 1'b1;
    else if (accept) alarm_q <= 1'b0;
  end
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scoreboard bench for parking_gate_ctrl (TRAVEL=4, HOLD=16, CAPACITY=8).
module tb_parking_gate_ctrl;
  logic clk = 0, reset = 0, grant = 0, beam = 0, exit_car = 0;
  logic motor_up, motor_down, gate_open, full, alarm;
  logic [3:0] occupancy;
  int cyc = 0, checks = 0, errors = 0;
  logic al = 0;
  typedef struct {
    string nm;
    int    cyc;
    logic [8:0] exp;
  } item_t;
  item_t sb[$];

  parking_gate_ctrl #(.CAPACITY(8), .CNT_W(4), .TRAVEL_CYCLES(4), .HOLD_MAX(16)) dut (
    .clk(clk), .reset(reset), .grant(grant), .beam(beam), .exit_car(exit_car),
    .motor_up(motor_up), .motor_down(motor_down), .gate_open(gate_open),
    .occupancy(occupancy), .full(full), .alarm(alarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every queued expectation that is due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item_t e;
      logic [8:0] obs;
      e = sb.pop_front();
      obs = {motor_up, motor_down, gate_open, full, alarm, occupancy};
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got up/dn/op/full/alarm/occ=%b required=%b", e.nm, e.cyc, obs, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string nm, input bit up, input bit dn, input bit op, input int occ);
    item_t e;
    e.nm  = nm;
    e.cyc = cyc;
    e.exp = {up, dn, op, occ == 8, al, 4'(occ)};
    sb.push_back(e);
  endtask

  task automatic cyc_n(input int n, input string nm, input bit up, input bit dn, input bit op, input int occ);
    for (int i = 0; i < n; i++) begin
      step();
      ex(nm, up, dn, op, occ);
    end
  endtask

  task automatic car_in(input int ob, input bit with_exit);
    int oa;
    oa = with_exit ? ob : ob + 1;
    grant = 1;
    cyc_n(4, "in_up", 1, 0, 0, ob);
    grant = 0;
    cyc_n(1, "in_open", 0, 0, 1, ob);
    beam = 1;
    cyc_n(1, "in_beam", 0, 0, 1, ob);
    beam = 0;
    exit_car = with_exit;
    cyc_n(1, "in_fall", 0, 1, 0, oa);
    exit_car = 0;
    cyc_n(3, "in_down", 0, 1, 0, oa);
    cyc_n(1, "in_closed", 0, 0, 0, oa);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d queue=%0d", cyc, sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    cyc_n(2, "reset", 0, 0, 0, 0);
    reset = 1;
    // basic entry
    grant = 1;
    cyc_n(4, "t1_up", 1, 0, 0, 0);
    cyc_n(1, "t1_open", 0, 0, 1, 0);
    beam = 1;
    cyc_n(3, "t1_beam", 0, 0, 1, 0);
    beam = 0;
    cyc_n(2, "t1_down", 0, 1, 0, 1);
    grant = 0;
    cyc_n(2, "t1_down2", 0, 1, 0, 1);
    cyc_n(3, "t1_closed", 0, 0, 0, 1);
    // empty timeout
    grant = 1;
    cyc_n(4, "t2_up", 1, 0, 0, 1);
    grant = 0;
    cyc_n(16, "t2_hold", 0, 0, 1, 1);
    cyc_n(4, "t2_down", 0, 1, 0, 1);
    cyc_n(2, "t2_closed", 0, 0, 0, 1);
    // fill the lot, refused grant, exit, reopen
    for (int k = 1; k < 8; k++) car_in(k, 0);
    grant = 1;
    cyc_n(3, "t3_refused", 0, 0, 0, 8);
    grant = 0;
    exit_car = 1;
    cyc_n(1, "t3_exit", 0, 0, 0, 7);
    exit_car = 0;
    car_in(7, 0);
    exit_car = 1;
    for (int j = 1; j <= 5; j++) cyc_n(1, "t3_drain", 0, 0, 0, 8 - j);
    exit_car = 0;
    // safety reversal after an empty hold
    grant = 1;
    cyc_n(4, "t4_up", 1, 0, 0, 3);
    grant = 0;
    cyc_n(16, "t4_hold", 0, 0, 1, 3);
    cyc_n(2, "t4_close", 0, 1, 0, 3);
    beam = 1;
    cyc_n(1, "t4_reverse", 1, 0, 0, 3);
    beam = 0;
    cyc_n(3, "t4_up2", 1, 0, 0, 3);
    cyc_n(1, "t4_open2", 0, 0, 1, 3);
    beam = 1;
    cyc_n(1, "t4_beam", 0, 0, 1, 3);
    beam = 0;
    cyc_n(4, "t4_down", 0, 1, 0, 4);
    cyc_n(1, "t4_closed", 0, 0, 0, 4);
    exit_car = 1;
    cyc_n(1, "t4_exit", 0, 0, 0, 3);
    exit_car = 0;
    // entry and exit together at 3
    car_in(3, 1);
    // forced-entry alarm
    beam = 1;
`ifdef GATE_ALARM_EN
    al = 1;
`endif
    cyc_n(1, "t6_alarm_set", 0, 0, 0, 3);
    beam = 0;
    cyc_n(2, "t6_alarm_hold", 0, 0, 0, 3);
    grant = 1;
    al = 0;
    cyc_n(2, "t6_alarm_clr", 1, 0, 0, 3);
    // reset mid-opening; grant high at release counts as a rise
    reset = 0;
    cyc_n(1, "t7_reset", 0, 0, 0, 0);
    reset = 1;
    cyc_n(4, "t7_rise", 1, 0, 0, 0);
    grant = 0;
    cyc_n(16, "t7_hold", 0, 0, 1, 0);
    cyc_n(4, "t7_down", 0, 1, 0, 0);
    exit_car = 1;
    cyc_n(2, "t7_exit_at_0", 0, 0, 0, 0);
    exit_car = 0;
    step();
    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
